// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits 11 round keys over a valid/ready handshake, one per 2 cycles.
// Optional feature macro AES_KEYEXP_LAST_RK_EN adds a last_rk / last_rk_valid capture of round key 10.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry for input x sits at bits [(255-x)*8 +: 8], i.e. {~x, 3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         done
`ifdef AES_KEYEXP_LAST_RK_EN
  ,
  output logic [127:0] last_rk,
  output logic         last_rk_valid
`endif
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, EMIT, EXPAND} state_t;
  state_t state, state_nxt;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t, n0, n1, n2, n3;
  logic [NUM_LANES-1:0][7:0] sub;
  logic [7:0]  rcon;
  logic        load, expand, hs, last_hs;

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[i*8 +: 8]), .y(sub[i]));
  end

  // Rcon for the key being produced (index rk_idx+1).
  always_comb begin
    rcon = 8'h00;
    case (rk_idx)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_valid = (state == EMIT);
  assign busy     = (state != IDLE);
  assign rk_out   = {w0, w1, w2, w3};
  assign hs       = rk_valid & rk_ready;
  assign last_hs  = hs & (rk_idx == 4'd10);

  // done is high on the first IDLE cycle, so start is gated by it there.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    expand    = 1'b0;
    case (state)
      IDLE:   if (start && !done) begin
                state_nxt = EMIT;
                load      = 1'b1;
              end
      EMIT:   if (rk_ready) state_nxt = (rk_idx == 4'd10) ? IDLE : EXPAND;
      EXPAND: begin
                state_nxt = EMIT;
                expand    = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      rk_idx <= 4'd0;
      w0 <= '0; w1 <= '0; w2 <= '0; w3 <= '0;
    end else begin
      state <= state_nxt;
      done  <= last_hs;
      if (load) begin
        {w0, w1, w2, w3} <= key_in;
        rk_idx <= 4'd0;
      end else if (expand) begin
        {w0, w1, w2, w3} <= {n0, n1, n2, n3};
        rk_idx <= rk_idx + 4'd1;
      end
    end
  end

`ifdef AES_KEYEXP_LAST_RK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rk       <= '0;
      last_rk_valid <= 1'b0;
    end else if (last_hs) begin
      last_rk       <= rk_out;
      last_rk_valid <= 1'b1;
    end else if (load) begin
      last_rk_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand; expected round keys come from an arithmetic AES model.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, rk_valid, done;
  logic         rk_ready = 1'b0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KEYEXP_LAST_RK_EN
  logic [127:0] last_rk;
  logic         last_rk_valid;
`endif

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_idx(rk_idx), .rk_out(rk_out), .done(done)
`ifdef AES_KEYEXP_LAST_RK_EN
    , .last_rk(last_rk), .last_rk_valid(last_rk_valid)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct packed { logic [3:0] idx; logic [127:0] key; } exp_t;
  exp_t exp_q[$];
  logic [7:0] sb [256];
  int errors = 0;
  int checks = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from GF(2^8) inverse + affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc = 8'h01;
    {w0, w1, w2, w3} = key;
    exp_q.push_back('{idx: 4'd0, key: key});
    for (int r = 1; r <= 10; r++) begin
      t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_q.push_back('{idx: 4'(r), key: {w0, w1, w2, w3}});
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy, rk_valid, done, rk_idx, rk_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b vld=%b done=%b idx=%0d out=%h required all zero", busy, rk_valid, done, rk_idx, rk_out);
    end
`ifdef AES_KEYEXP_LAST_RK_EN
    checks++;
    if ({last_rk_valid, last_rk} !== '0) begin
      errors++; $display("FAIL reset_last_rk got vld=%b rk=%h required 0", last_rk_valid, last_rk);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int n = 0, guard = 0, t0;
    exp_t e;
    push_expected(FIPS_KEY);
    key_in = FIPS_KEY; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL fips_first_valid got vld=%b busy=%b required 1 1", rk_valid, busy);
    end
    t0 = cycle;
    while (n < 11 && guard < 100) begin
      if (rk_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_idx !== e.idx || rk_out !== e.key) begin
          errors++; $display("FAIL fips_rk got idx=%0d %h required idx=%0d %h", rk_idx, rk_out, e.idx, e.key);
        end
        if (n == 1) begin
          checks++;
          if (rk_out !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got %h required %h", rk_out, FIPS_RK1); end
        end
        if (n == 10) begin
          checks++;
          if (rk_out !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10 got %h required %h", rk_out, FIPS_RK10); end
        end
        n++;
      end
      @(negedge clk); guard++;
    end
    checks++;
    if (n != 11 || done !== 1'b1 || cycle - t0 != 21) begin
      errors++; $display("FAIL fips_done_timing got keys=%0d done=%b cycles=%0d required 11 1 21", n, done, cycle - t0);
    end
`ifdef AES_KEYEXP_LAST_RK_EN
    checks++;
    if (last_rk !== FIPS_RK10 || last_rk_valid !== 1'b1) begin
      errors++; $display("FAIL fips_last_rk got vld=%b %h required 1 %h", last_rk_valid, last_rk, FIPS_RK10);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fips_done_pulse got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      logic [127:0] key;
      int n = 0, guard = 0, stall;
      key = (k == 0) ? '0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      push_expected(key);
      rk_ready = 1'b0; key_in = key; start = 1'b1;
      @(negedge clk); start = 1'b0;
      stall = $urandom_range(0, 5);
      while (n < 11 && guard < 400) begin
        if (rk_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0 || rk_idx !== exp_q[0].idx || rk_out !== exp_q[0].key) begin
            errors++; $display("FAIL bp_rk key%0d got idx=%0d %h required idx=%0d %h", k, rk_idx, rk_out, exp_q[0].idx, exp_q[0].key);
          end
          if (k == 0 && (n == 1 || n == 10)) begin
            checks++;
            if (rk_out !== ((n == 1) ? ZERO_RK1 : ZERO_RK10)) begin
              errors++; $display("FAIL zero_key_rk%0d got %h required %h", n, rk_out, (n == 1) ? ZERO_RK1 : ZERO_RK10);
            end
          end
          if (stall == 0) begin
            rk_ready = 1'b1; void'(exp_q.pop_front()); n++;
            stall = $urandom_range(0, 5);
          end else begin
            rk_ready = 1'b0; stall--;
          end
        end else begin
          rk_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk); guard++;
      end
      rk_ready = 1'b0;
      checks++;
      if (n != 11 || done !== 1'b1) begin
        errors++; $display("FAIL bp_done key%0d got keys=%0d done=%b required 11 1", k, n, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] kb = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] kc = 128'hffeeddccbbaa99887766554433221100;
    int n = 0, guard = 0;
    exp_t e;
    push_expected(FIPS_KEY);
    key_in = FIPS_KEY; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    while (n < 11 && guard < 100) begin
      if (rk_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_idx !== e.idx || rk_out !== e.key) begin
          errors++; $display("FAIL busy_start_rk got idx=%0d %h required idx=%0d %h", rk_idx, rk_out, e.idx, e.key);
        end
        n++;
      end
      key_in = kb; start = 1'($urandom_range(0, 1));
      @(negedge clk); guard++;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %b required 1", done); end
    key_in = kb; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL start_at_done_ignored got busy=%b vld=%b required 0 0", busy, rk_valid);
    end
`ifdef AES_KEYEXP_LAST_RK_EN
    checks++;
    if (last_rk_valid !== 1'b1 || last_rk !== FIPS_RK10) begin
      errors++; $display("FAIL last_rk_hold got vld=%b %h required 1 %h", last_rk_valid, last_rk, FIPS_RK10);
    end
`endif
    push_expected(kc);
    key_in = kc;
    @(negedge clk); start = 1'b0;
`ifdef AES_KEYEXP_LAST_RK_EN
    checks++;
    if (last_rk_valid !== 1'b0) begin errors++; $display("FAIL last_rk_clear got %b required 0", last_rk_valid); end
`endif
    n = 0; guard = 0;
    while (n < 11 && guard < 100) begin
      if (rk_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_idx !== e.idx || rk_out !== e.key) begin
          errors++; $display("FAIL idle_start_rk got idx=%0d %h required idx=%0d %h", rk_idx, rk_out, e.idx, e.key);
        end
        n++;
      end
      @(negedge clk); guard++;
    end
    checks++;
    if (n != 11 || done !== 1'b1) begin errors++; $display("FAIL idle_start_done got keys=%0d done=%b required 11 1", n, done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int guard = 0, n = 0, done_seen = 0;
    exp_t e;
    push_expected({$urandom(), $urandom(), $urandom(), $urandom()});
    key_in = exp_q[0].key; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(rk_valid === 1'b1 && rk_idx == 4'd5) && guard < 100) begin
      if (rk_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_idx !== e.idx || rk_out !== e.key) begin
          errors++; $display("FAIL pre_reset_rk got idx=%0d %h required idx=%0d %h", rk_idx, rk_out, e.idx, e.key);
        end
      end
      @(negedge clk); guard++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (guard >= 100 || {busy, rk_valid, done, rk_idx, rk_out} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b vld=%b done=%b idx=%0d out=%h required all zero", busy, rk_valid, done, rk_idx, rk_out);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    repeat (5) begin @(negedge clk); if (done === 1'b1) done_seen++; end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL reset_no_done got %0d pulses required 0", done_seen); end
    push_expected(FIPS_KEY);
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (n < 11 && guard < 100) begin
      if (rk_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rk_idx !== e.idx || rk_out !== e.key) begin
          errors++; $display("FAIL post_reset_rk got idx=%0d %h required idx=%0d %h", rk_idx, rk_out, e.idx, e.key);
        end
        n++;
      end
      @(negedge clk); guard++;
    end
    checks++;
    if (n != 11 || done !== 1'b1) begin errors++; $display("FAIL post_reset_done got keys=%0d done=%b required 11 1", n, done); end
    @(negedge clk);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
